// File: rtl/cpu_pkg.sv
// Shared types and constants for the 8-bit execution datapath.
// Opcode encodings, widths and the write-back source selector.
package cpu_pkg;

  localparam int DATA_W     = 8;
  localparam int REG_ADDR_W = 4;
  localparam int NUM_REGS   = 1 << REG_ADDR_W;

  localparam logic [2:0] ADD = 3'b000;
  localparam logic [2:0] SUB = 3'b001;
  localparam logic [2:0] AND = 3'b010;
  localparam logic [2:0] OR  = 3'b011;
  localparam logic [2:0] XOR = 3'b100;
  localparam logic [2:0] NOT = 3'b101;
  localparam logic [2:0] SHL = 3'b110;
  localparam logic [2:0] SHR = 3'b111;

  typedef logic [DATA_W-1:0]     data_t;
  typedef logic [REG_ADDR_W-1:0] raddr_t;

  typedef enum logic [1:0] {
    WB_NONE,
    WB_IMM,
    WB_RAM,
    WB_ALU
  } wb_src_e;

  function automatic wb_src_e wb_src(
    input logic imm,
    input logic load,
    input logic alu
  );
    wb_src_e s;
    s = WB_NONE;
    priority case (1'b1)
      imm:     s = WB_IMM;
      load:    s = WB_RAM;
      alu:     s = WB_ALU;
      default: s = WB_NONE;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/cpu_datapath_alu.sv
// Combinational 8-bit ALU: result plus zero and carry flags.
// Carry doubles as borrow for SUB and as the shifted-out bit.
module alu8
  import cpu_pkg::*;
(
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [2:0]        opcode,
  output logic [DATA_W-1:0] result,
  output logic              zero,
  output logic              carry
);

  logic [DATA_W:0] sum;
  logic [DATA_W:0] diff;

  assign sum  = {1'b0, a} + {1'b0, b};
  // Top bit of the widened difference is set exactly when a < b.
  assign diff = {1'b0, a} - {1'b0, b};

  always_comb begin
    result = '0;
    carry  = 1'b0;
    unique case (opcode)
      ADD: begin
        result = sum[DATA_W-1:0];
        carry  = sum[DATA_W];
      end
      SUB: begin
        result = diff[DATA_W-1:0];
        carry  = diff[DATA_W];
      end
      AND: result = a & b;
      OR:  result = a | b;
      XOR: result = a ^ b;
      NOT: result = ~a;
      SHL: begin
        result = {a[DATA_W-2:0], 1'b0};
        carry  = a[DATA_W-1];
      end
      SHR: begin
        result = {1'b0, a[DATA_W-1:1]};
        carry  = a[0];
      end
    endcase
  end

  assign zero = (result == '0);

endmodule

// File: rtl/cpu_datapath.sv
// Execution datapath: 16x8 register file, ALU and write-back mux.
// Reads are asynchronous; writes land on the rising clock edge.
module cpu_datapath
  import cpu_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  write_alu,
  input  logic [2:0]            alu_opcode,
  input  logic [DATA_W-1:0]     imm_data,
  input  logic [DATA_W-1:0]     ram_data,
  input  logic [REG_ADDR_W-1:0] write_addr,
  input  logic [REG_ADDR_W-1:0] ra_addr,
  input  logic [REG_ADDR_W-1:0] rb_addr,
  input  logic                  write_en,
  input  logic                  is_load,
  input  logic                  imm_flag,
  input  logic                  cpu_paused,
  output logic [DATA_W-1:0]     read_a,
  output logic [DATA_W-1:0]     read_b,
  output logic                  alu_zero,
  output logic                  alu_carry
);

  data_t   regs [NUM_REGS];
  data_t   alu_y;
  data_t   wb_data;
  wb_src_e src;
  logic    wr_strobe;

  // Reg0 is hardwired to zero on both read ports.
  assign read_a = (ra_addr == '0) ? '0 : regs[ra_addr];
  assign read_b = (rb_addr == '0) ? '0 : regs[rb_addr];

  alu8 u_alu (
    .a      (read_a),
    .b      (read_b),
    .opcode (alu_opcode),
    .result (alu_y),
    .zero   (alu_zero),
    .carry  (alu_carry)
  );

  assign src = wb_src(imm_flag, is_load, write_alu);

  always_comb begin
    wb_data = '0;
    unique case (src)
      WB_IMM:  wb_data = imm_data;
      WB_RAM:  wb_data = ram_data;
      WB_ALU:  wb_data = alu_y;
      WB_NONE: wb_data = '0;
    endcase
  end

  assign wr_strobe = write_en
                   & ~cpu_paused
                   & (src != WB_NONE)
                   & (write_addr != '0);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else if (wr_strobe) begin
      regs[write_addr] <= wb_data;
    end
  end

endmodule

// File: tb/tb_cpu_datapath.sv
// Self-checking bench for cpu_datapath.
// Expectations are queued from a reference model, then popped at sample time.
module tb_cpu_datapath;
  import cpu_pkg::*;

  logic       clk;
  logic       rst_n;
  logic       write_alu;
  logic [2:0] alu_opcode;
  logic [7:0] imm_data;
  logic [7:0] ram_data;
  logic [3:0] write_addr;
  logic [3:0] ra_addr;
  logic [3:0] rb_addr;
  logic       write_en;
  logic       is_load;
  logic       imm_flag;
  logic       cpu_paused;
  logic [7:0] read_a;
  logic [7:0] read_b;
  logic       alu_zero;
  logic       alu_carry;

  cpu_datapath dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .write_alu  (write_alu),
    .alu_opcode (alu_opcode),
    .imm_data   (imm_data),
    .ram_data   (ram_data),
    .write_addr (write_addr),
    .ra_addr    (ra_addr),
    .rb_addr    (rb_addr),
    .write_en   (write_en),
    .is_load    (is_load),
    .imm_flag   (imm_flag),
    .cpu_paused (cpu_paused),
    .read_a     (read_a),
    .read_b     (read_b),
    .alu_zero   (alu_zero),
    .alu_carry  (alu_carry)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      tag;
    logic [7:0] exp;
  } sb_item_t;

  sb_item_t   sb [$];
  logic [7:0] mdl [16];
  int         checks = 0;
  int         errors = 0;

  task automatic check(input string tag, input logic [7:0] got,
                       input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %02h expected %02h", tag, got, exp);
    end
  endtask

  task automatic push(input string tag, input logic [7:0] exp);
    sb.push_back('{tag, exp});
  endtask

  task automatic pop_check(input logic [7:0] got);
    sb_item_t it;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL sb_empty: got %02h expected queued item", got);
    end else begin
      it = sb.pop_front();
      check(it.tag, got, it.exp);
    end
  endtask

  // Returns {carry, result}.
  function automatic logic [8:0] ref_alu(input logic [2:0] op,
                                         input logic [7:0] a,
                                         input logic [7:0] b);
    logic [8:0] r;
    case (op)
      3'd0: r = {1'b0, a} + {1'b0, b};
      3'd1: r = {(a < b), a - b};
      3'd2: r = {1'b0, a & b};
      3'd3: r = {1'b0, a | b};
      3'd4: r = {1'b0, a ^ b};
      3'd5: r = {1'b0, ~a};
      3'd6: r = {a[7], a[6:0], 1'b0};
      default: r = {a[0], 1'b0, a[7:1]};
    endcase
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    write_en  = 1'b0;
    imm_flag  = 1'b0;
    is_load   = 1'b0;
    write_alu = 1'b0;
  endtask

  task automatic wr_imm(input logic [3:0] ad, input logic [7:0] d);
    write_addr = ad;
    imm_data   = d;
    imm_flag   = 1'b1;
    write_en   = 1'b1;
    tick();
    idle();
    if (ad != 4'd0) mdl[ad] = d;
  endtask

  task automatic rd(input string tag, input logic [3:0] a,
                    input logic [3:0] b);
    ra_addr = a;
    rb_addr = b;
    push({tag, "_a"}, mdl[a]);
    push({tag, "_b"}, mdl[b]);
    #1;
    pop_check(read_a);
    pop_check(read_b);
  endtask

  task automatic flags(input string tag);
    logic [8:0] r;
    r = ref_alu(alu_opcode, mdl[ra_addr], mdl[rb_addr]);
    push({tag, "_z"}, {7'd0, (r[7:0] == 8'h00)});
    push({tag, "_c"}, {7'd0, r[8]});
    #1;
    pop_check({7'd0, alu_zero});
    pop_check({7'd0, alu_carry});
  endtask

  logic [8:0] r;
  logic [7:0] va;
  logic [7:0] vb;
  logic       seen_borrow;
  logic       chk_fd;

  initial begin
    rst_n = 1'b0;
    alu_opcode = ADD;
    imm_data = 8'h00;
    ram_data = 8'h00;
    write_addr = 4'd0;
    ra_addr = 4'd0;
    rb_addr = 4'd0;
    cpu_paused = 1'b0;
    idle();
    for (int i = 0; i < 16; i++) mdl[i] = 8'h00;

    // Reset state
    tick();
    rst_n = 1'b1;
    rd("rst_r", 4'd5, 4'd9);
    flags("rst_flag");

    // Fill and sweep
    for (int i = 0; i < 16; i++) wr_imm(4'(i), 8'(i * 8'h11));
    for (int i = 0; i < 16; i++) begin
      rd("fill", 4'(i), 4'(15 - i));
      #2;
    end

    // Overwrite, with no write-through before the edge
    write_addr = 4'd3;
    imm_data = 8'hAA;
    imm_flag = 1'b1;
    write_en = 1'b1;
    rd("nobypass", 4'd3, 4'd3);
    tick();
    idle();
    mdl[3] = 8'hAA;
    rd("ovr3", 4'd3, 4'd3);
    wr_imm(4'd0, 8'h55);
    rd("ovr0", 4'd0, 4'd0);

    // Write blocked: enable low, paused, no source
    write_addr = 4'd5;
    imm_data = 8'h11;
    imm_flag = 1'b1;
    tick();
    write_en = 1'b1;
    cpu_paused = 1'b1;
    tick();
    cpu_paused = 1'b0;
    imm_flag = 1'b0;
    tick();
    idle();
    rd("wr_block", 4'd5, 4'd5);

    // Source priority
    imm_data = 8'h3C;
    ram_data = 8'hC3;
    write_addr = 4'd11;
    write_en = 1'b1;
    imm_flag = 1'b1;
    is_load = 1'b1;
    write_alu = 1'b1;
    tick();
    mdl[11] = 8'h3C;
    imm_flag = 1'b0;
    write_addr = 4'd13;
    tick();
    idle();
    mdl[13] = 8'hC3;
    rd("prio", 4'd11, 4'd13);

    // Opcode sweep: flags before write, result via write-back
    for (int op = 0; op < 8; op++) begin
      for (int k = 0; k < 3; k++) begin
        va = 8'($urandom);
        vb = 8'($urandom);
        wr_imm(4'd8, va);
        wr_imm(4'd9, vb);
        ra_addr = 4'd8;
        rb_addr = 4'd9;
        alu_opcode = 3'(op);
        flags("op_flag");
        r = ref_alu(3'(op), va, vb);
        write_addr = 4'd10;
        write_alu = 1'b1;
        write_en = 1'b1;
        tick();
        idle();
        mdl[10] = r[7:0];
        rd("op_res", 4'd10, 4'd10);
      end
    end

    // ADD accumulation
    wr_imm(4'd1, 8'h00);
    wr_imm(4'd2, 8'h01);
    ra_addr = 4'd1;
    rb_addr = 4'd2;
    alu_opcode = ADD;
    write_addr = 4'd1;
    write_alu = 1'b1;
    write_en = 1'b1;
    for (int k = 0; k < 64; k++) begin
      flags("add_acc");
      r = ref_alu(ADD, mdl[1], mdl[2]);
      tick();
      mdl[1] = r[7:0];
    end
    idle();
    #1;
    check("add_final", read_a, 8'h40);

    // SUB accumulation
    wr_imm(4'd12, 8'h7F);
    wr_imm(4'd6, 8'h0A);
    ra_addr = 4'd12;
    rb_addr = 4'd6;
    alu_opcode = SUB;
    write_addr = 4'd12;
    write_alu = 1'b1;
    write_en = 1'b1;
    seen_borrow = 1'b0;
    chk_fd = 1'b0;
    for (int k = 0; k < 25; k++) begin
      #1;
      if (chk_fd) begin
        check("sub_borrow_res", read_a, 8'hFD);
        chk_fd = 1'b0;
      end
      if (alu_carry && !seen_borrow) begin
        seen_borrow = 1'b1;
        chk_fd = 1'b1;
        check("sub_borrow_op", read_a, 8'h07);
      end
      flags("sub_acc");
      r = ref_alu(SUB, mdl[12], mdl[6]);
      tick();
      mdl[12] = r[7:0];
    end
    idle();
    #1;
    check("sub_seen", {7'd0, seen_borrow}, 8'h01);
    check("sub_final", read_a, 8'h85);

    // SHL of 0x80
    wr_imm(4'd7, 8'h80);
    ra_addr = 4'd7;
    rb_addr = 4'd7;
    alu_opcode = SHL;
    #1;
    check("shl_z", {7'd0, alu_zero}, 8'h01);
    check("shl_c", {7'd0, alu_carry}, 8'h01);

    // Reset mid-sequence beats a concurrent write
    write_addr = 4'd4;
    imm_data = 8'h99;
    imm_flag = 1'b1;
    write_en = 1'b1;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    idle();
    for (int i = 0; i < 16; i++) mdl[i] = 8'h00;
    for (int i = 0; i < 16; i++) rd("rst_mid", 4'(i), 4'(15 - i));
    alu_opcode = ADD;
    #1;
    check("rst_mid_z", {7'd0, alu_zero}, 8'h01);

    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL sb_left: got %0d items expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
